// File: rtl/rx_corr_peak_search.sv
// Replays one 128-sample correlation window from the buffer and reports the peak magnitude, its index and a threshold hit.
// One request outstanding at a time: wash/next trigger, then wait up to TIMEOUT-1 cycles for ready; erx_en low freezes everything.
module rx_corr_peak_search #(
    parameter int NUM_SAMPLES = 128,
    parameter int TIMEOUT     = 15
) (
    input  logic        crx_clk,
    input  logic        rrx_rst,
    input  logic        erx_en,
    input  logic        istart,
    input  logic [1:0]  iseq,
    input  logic [31:0] ithreshold,
    output logic        owash_trigger,
    output logic [1:0]  oreceived_seq,
    output logic        onext_sample_trigger,
    input  logic [31:0] icorr_sample,
    input  logic        icorr_sample_ready,
    output logic [31:0] opeak_value,
    output logic [31:0] opeak_abs,
    output logic [6:0]  opeak_index,
    output logic        odetected,
    output logic        odone,
    output logic        oerror,
    output logic        obusy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [6:0]    LAST_IDX = 7'(NUM_SAMPLES - 1);
    localparam logic [6:0]    IDX_ONE  = 7'd1;
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WASH,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [6:0]    count;
    logic [TW-1:0] tmo;
    logic [1:0]    seq_q;
    logic [31:0]   thr_q;
    logic [31:0]   peak_value;
    logic [31:0]   peak_abs;
    logic [6:0]    peak_index;
    logic          detected;

    logic [31:0]   sample_abs;
    logic          sample_wins;
    logic [31:0]   final_abs;

    // Two's-complement negate in unsigned space: 0x80000000 maps onto itself, which is exactly 2^31.
    always_comb begin
        sample_abs  = icorr_sample[31] ? (~icorr_sample + 32'd1) : icorr_sample;
        sample_wins = sample_abs > peak_abs;
        final_abs   = sample_wins ? sample_abs : peak_abs;
    end

    always_comb begin
        state_nxt            = state;
        owash_trigger        = 1'b0;
        onext_sample_trigger = 1'b0;
        odone                = 1'b0;
        oerror               = 1'b0;
        obusy                = 1'b0;
        case (state)
            S_IDLE: begin
                if (istart) state_nxt = S_WASH;
            end
            S_WASH: begin
                owash_trigger = erx_en;
                obusy         = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                obusy = 1'b1;
                if (icorr_sample_ready) begin
                    state_nxt = (count == LAST_IDX) ? S_DONE : S_NEXT;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_NEXT: begin
                onext_sample_trigger = erx_en;
                obusy                = 1'b1;
                state_nxt            = S_WAIT;
            end
            S_DONE: begin
                odone     = erx_en;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                oerror    = erx_en;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The timeout counter includes the trigger cycle, so an abort lands exactly TIMEOUT cycles after the trigger.
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state      <= S_IDLE;
            count      <= '0;
            tmo        <= '0;
            seq_q      <= '0;
            thr_q      <= '0;
            peak_value <= '0;
            peak_abs   <= '0;
            peak_index <= '0;
            detected   <= 1'b0;
        end else if (erx_en) begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (istart) begin
                        seq_q      <= iseq;
                        thr_q      <= ithreshold;
                        peak_value <= '0;
                        peak_abs   <= '0;
                        peak_index <= '0;
                        count      <= '0;
                        detected   <= 1'b0;
                    end
                end
                S_WASH, S_NEXT: begin
                    tmo <= TMO_ONE;
                end
                S_WAIT: begin
                    if (icorr_sample_ready) begin
                        tmo <= '0;
                        if (sample_wins) begin
                            peak_value <= icorr_sample;
                            peak_abs   <= sample_abs;
                            peak_index <= count;
                        end
                        if (count == LAST_IDX) begin
                            detected <= final_abs >= thr_q;
                        end else begin
                            count <= count + IDX_ONE;
                        end
                    end else begin
                        tmo <= tmo + TMO_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oreceived_seq = seq_q;
    assign opeak_value   = peak_value;
    assign opeak_abs     = peak_abs;
    assign opeak_index   = peak_index;
    assign odetected     = detected;

endmodule

// File: tb/tb_rx_corr_peak_search.sv
// Bench for rx_corr_peak_search: a behavioural correlation-buffer replays a stored window, results are checked against a peak model.
module tb_rx_corr_peak_search;

    localparam int N   = 128;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        istart;
    logic [1:0]  iseq;
    logic [31:0] ithr;
    logic        owash;
    logic [1:0]  orseq;
    logic        onext;
    logic [31:0] csample;
    logic        cready;
    logic [31:0] pval;
    logic [31:0] pabs;
    logic [6:0]  pidx;
    logic        pdet;
    logic        odone;
    logic        oerror;
    logic        obusy;

    rx_corr_peak_search #(.NUM_SAMPLES(N), .TIMEOUT(TMO)) dut (
        .crx_clk(clk), .rrx_rst(rst), .erx_en(en), .istart(istart), .iseq(iseq),
        .ithreshold(ithr), .owash_trigger(owash), .oreceived_seq(orseq),
        .onext_sample_trigger(onext), .icorr_sample(csample), .icorr_sample_ready(cready),
        .opeak_value(pval), .opeak_abs(pabs), .opeak_index(pidx), .odetected(pdet),
        .odone(odone), .oerror(oerror), .obusy(obusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] win [N];
    int stop_at = N;
    int ptr = 0, dly = 0, resp_idx = 0;
    int n_wash = 0, n_next = 0, n_done = 0, n_err = 0, n_dis = 0;
    int wash_cyc = 0, last_next_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [1:0] wash_seq = '0;

    // Buffer model: answers 2 cycles after each trigger from win[], sees only what the DUT sees while enabled.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            cready = 1'b0;
            dly    = 0;
        end else if (en) begin
            cready = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0 && ptr < stop_at) begin
                    cready   = 1'b1;
                    csample  = win[ptr];
                    resp_idx = ptr + 1;
                end
            end
            if (owash) begin ptr = 0; dly = 2; n_wash++; wash_cyc = cyc; wash_seq = orseq; end
            if (onext) begin ptr++; dly = 2; n_next++; last_next_cyc = cyc; end
            if (odone) begin n_done++; done_cyc = cyc; end
            if (oerror) begin n_err++; err_cyc = cyc; end
        end else if (owash || onext || odone || oerror) begin
            n_dis++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Peak over the first n samples: largest |x|, earliest index on ties.
    task automatic model(input int n, output logic [31:0] v, output logic [31:0] a, output logic [31:0] idx);
        longint best;
        longint m;
        best = 0; v = '0; idx = '0;
        for (int i = 0; i < n; i++) begin
            m = longint'($signed(win[i]));
            if (m < 0) m = -m;
            if (m > best) begin best = m; v = win[i]; idx = 32'(i); end
        end
        a = best[31:0];
    endtask

    task automatic check_results(input string tag, input int n, input logic [31:0] thr, input bit completed);
        logic [31:0] v, a, idx;
        model(n, v, a, idx);
        chk({tag, "_value"}, pval, v);
        chk({tag, "_abs"}, pabs, a);
        chk({tag, "_index"}, {25'd0, pidx}, idx);
        chk({tag, "_detected"}, {31'd0, pdet}, {31'd0, completed && (a >= thr)});
    endtask

    task automatic do_scan(input logic [1:0] s, input logic [31:0] th, output int res, output int dur);
        int d0, e0, w0, st;
        d0 = n_done; e0 = n_err; w0 = n_wash;
        @(negedge clk);
        istart = 1'b1; iseq = s; ithr = th; st = cyc;
        @(negedge clk);
        istart = 1'b0; iseq = s + 2'd1; ithr = $urandom;
        chk("busy_after_start", {31'd0, obusy}, 32'd1);
        res = 0;
        for (int i = 0; i < 3000 && res == 0; i++) begin
            @(negedge clk);
            #2;
            if (n_done != d0) res = 1;
            else if (n_err != e0) res = 2;
        end
        chk("scan_ended", {31'd0, res != 0}, 32'd1);
        chk("wash_latency", 32'(wash_cyc - st), 32'd1);
        chk("wash_count", 32'(n_wash - w0), 32'd1);
        dur = (res == 1 ? done_cyc : err_cyc) - st;
        @(negedge clk);
        chk("busy_after_end", {31'd0, obusy}, 32'd0);
    endtask

    initial begin
        int res, dur, dur0, nx0, w0, d0, e0;
        logic [31:0] thr, v, a, idx;

        rst = 1'b1; en = 1'b1; istart = 1'b0; iseq = '0; ithr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pulses", {26'd0, owash, onext, odone, oerror, obusy, pdet}, 32'd0);
        chk("reset_value", pval, 32'd0);
        chk("reset_abs_idx_seq", {pabs[22:0], pidx, orseq}, 32'd0);

        // Ramp 0..127 on sequence 2
        for (int i = 0; i < N; i++) win[i] = 32'(i);
        nx0 = n_next;
        do_scan(2'd2, 32'd100, res, dur);
        chk("ramp_done", 32'(res), 32'd1);
        chk("ramp_duration", 32'(dur), 32'(1 + 3 * N));
        chk("ramp_seq", {30'd0, wash_seq}, 32'd2);
        chk("ramp_next_count", 32'(n_next - nx0), 32'(N - 1));
        chk("ramp_value", pval, 32'd127);
        chk("ramp_index", {25'd0, pidx}, 32'd127);
        chk("ramp_detected", {31'd0, pdet}, 32'd1);

        // Single negative outlier below threshold
        for (int i = 0; i < N; i++) win[i] = 32'd5;
        win[40] = -32'sd900;
        do_scan(2'd0, 32'd1000, res, dur);
        chk("neg_done", 32'(res), 32'd1);
        chk("neg_value", pval, 32'hFFFF_FC7C);
        chk("neg_abs", pabs, 32'd900);
        chk("neg_index", {25'd0, pidx}, 32'd40);
        chk("neg_detected", {31'd0, pdet}, 32'd0);

        // Tie: first occurrence wins
        for (int i = 0; i < N; i++) win[i] = 32'd0;
        win[10] = 32'd700; win[90] = 32'd700;
        do_scan(2'd1, 32'd700, res, dur);
        check_results("tie", N, 32'd700, 1'b1);
        chk("tie_index", {25'd0, pidx}, 32'd10);

        // Most negative value
        for (int i = 0; i < N; i++) win[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
        win[3] = 32'h8000_0000;
        do_scan(2'd3, 32'h8000_0000, res, dur);
        chk("min_abs", pabs, 32'h8000_0000);
        chk("min_index", {25'd0, pidx}, 32'd3);
        chk("min_detected", {31'd0, pdet}, 32'd1);

        // Random windows, threshold exactly at and just above the peak
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) win[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1 << 20));
            model(N, v, a, idx);
            thr = a + 32'(t);
            do_scan(2'(t), thr, res, dur);
            chk("rand_done", 32'(res), 32'd1);
            check_results("rand", N, thr, 1'b1);
        end

        // Buffer stops answering after sample 20
        for (int i = 0; i < N; i++) win[i] = $urandom;
        stop_at = 21;
        d0 = n_done;
        do_scan(2'd1, 32'd0, res, dur);
        chk("tmo_error", 32'(res), 32'd2);
        chk("tmo_latency", 32'(err_cyc - last_next_cyc), 32'(TMO));
        chk("tmo_no_done", 32'(n_done - d0), 32'd0);
        check_results("tmo_partial", 21, 32'd0, 1'b0);
        stop_at = N;
        do_scan(2'd2, $urandom, res, dur);
        chk("tmo_recover", 32'(res), 32'd1);
        check_results("tmo_recover", N, ithr, 1'b0 || 1'b1);

        // Reset in the middle of a scan
        for (int i = 0; i < N; i++) win[i] = $urandom;
        @(negedge clk);
        istart = 1'b1; iseq = 2'd3; ithr = 32'd1;
        @(negedge clk);
        istart = 1'b0;
        for (int i = 0; i < 2000 && resp_idx < 60; i++) @(negedge clk);
        chk("rst_reached_60", {31'd0, resp_idx >= 60}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        d0 = n_done; e0 = n_err;
        chk("rst_busy", {31'd0, obusy}, 32'd0);
        chk("rst_value", pval, 32'd0);
        chk("rst_abs_idx_seq_det", {pabs[21:0], pidx, orseq, pdet}, 32'd0);
        repeat (40) @(negedge clk);
        chk("rst_quiet", 32'((n_done - d0) + (n_err - e0) + 32'(obusy)), 32'd0);

        // Reference run, then the same window with an ignored istart and a 5-cycle enable gap
        for (int i = 0; i < N; i++) win[i] = $urandom;
        thr = $urandom;
        do_scan(2'd1, thr, res, dur0);
        w0 = n_wash; nx0 = n_next;
        fork
            do_scan(2'd1, thr, res, dur);
            begin
                repeat (50) @(negedge clk);
                istart = 1'b1; iseq = 2'd3;
                @(negedge clk);
                istart = 1'b0;
                repeat (50) @(negedge clk);
                en = 1'b0;
                repeat (5) @(negedge clk);
                en = 1'b1;
            end
        join
        chk("gap_done", 32'(res), 32'd1);
        chk("gap_delay", 32'(dur - dur0), 32'd5);
        chk("gap_single_wash", 32'(n_wash - w0), 32'd1);
        chk("gap_seq", {30'd0, orseq}, 32'd1);
        chk("gap_next_count", 32'(n_next - nx0), 32'(N - 1));
        chk("gap_no_pulse_disabled", 32'(n_dis), 32'd0);
        check_results("gap", N, thr, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
